// File: rtl/mdc_pkg.sv
// Shared types and defaults for the multiplier display controller.
package mdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    SETTLE,
    LOAD,
    SHOW,
    STEP,
    ERR
  } state_t;

  localparam int unsigned SETTLE_CYC_DEF     = 2;
  localparam int unsigned BITS_PER_DIGIT_DEF = 4;
  localparam int unsigned MAX_OFFSET_DEF     = 1;
  localparam int unsigned TIMEOUT_CYC_DEF    = 64;

  // Wide enough for any sensible settle/step/watchdog length.
  localparam int unsigned CNT_W = 16;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/mdc_cycle_counter.sv
// Down-counter shared by the settle, step and watchdog phases.
// load takes priority; tc is high once the count has reached zero.
module mdc_cycle_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mult_display_ctrl.sv
// Sequences multiply -> BCD settle -> display load, and scrolls a 4-digit
// window over the 5-digit result. Optional watchdog: define MDC_WATCHDOG_EN.
module mult_display_ctrl
  import mdc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC     = SETTLE_CYC_DEF,
  parameter int unsigned BITS_PER_DIGIT = BITS_PER_DIGIT_DEF,
  parameter int unsigned MAX_OFFSET     = MAX_OFFSET_DEF,
  parameter int unsigned TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       scroll_l,
  input  logic       scroll_r,
  input  logic       mult_done,
  input  logic       neg_a,
  input  logic       neg_b,
  output logic       mult_start,
  output logic       sr_load,
  output logic       sr_en,
  output logic       sr_dir,
  output logic [1:0] offset,
  output logic       neg,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] OFF_MAX = 2'(MAX_OFFSET);

  state_t             state, state_nx;
  logic               cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   cnt_val;
  logic               go_mult, go_step, step_done, step_dir;

  mdc_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    go_mult   = 1'b0;
    go_step   = 1'b0;
    step_done = 1'b0;
    step_dir  = sr_dir;

    unique case (state)
      IDLE: if (start) go_mult = 1'b1;
      MULT: begin
        cnt_en = 1'b1;
        if (mult_done) begin
          state_nx = SETTLE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETTLE_CYC - 1);
        end
`ifdef MDC_WATCHDOG_EN
        else if (cnt_tc) begin
          state_nx = ERR;
        end
`endif
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_nx = LOAD;
      end
      LOAD: state_nx = SHOW;
      SHOW: begin
        // start outranks scrolls; simultaneous left+right is dropped.
        if (start) begin
          go_mult = 1'b1;
        end else if (scroll_l && !scroll_r && (offset < OFF_MAX)) begin
          go_step  = 1'b1;
          step_dir = DIR_LEFT;
        end else if (scroll_r && !scroll_l && (offset != '0)) begin
          go_step  = 1'b1;
          step_dir = DIR_RIGHT;
        end
      end
      STEP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          step_done = 1'b1;
          state_nx  = SHOW;
        end
      end
      ERR: if (start) go_mult = 1'b1;
      default: state_nx = IDLE;
    endcase

    // Watchdog length is loaded on every MULT entry; only the watchdog build acts on it.
    if (go_mult) begin
      state_nx = MULT;
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(TIMEOUT_CYC - 1);
    end
    if (go_step) begin
      state_nx = STEP;
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(BITS_PER_DIGIT - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      offset <= '0;
      neg    <= 1'b0;
      sr_dir <= DIR_RIGHT;
    end else begin
      state <= state_nx;
      if (go_mult) begin
        neg    <= neg_a ^ neg_b;
        offset <= '0;
      end
      if (go_step) sr_dir <= step_dir;
      if (step_done) offset <= (sr_dir == DIR_LEFT) ? offset + 2'd1 : offset - 2'd1;
    end
  end

  assign mult_start = (state == MULT);
  assign sr_load    = (state == LOAD);
  assign sr_en      = (state == STEP);
  assign busy       = !((state == IDLE) || (state == SHOW));

`ifdef MDC_WATCHDOG_EN
  assign err = (state == ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_display_ctrl.sv
// Randomized bench for mult_display_ctrl against a transaction-level model
// of product sign, window offset and display activity.
module tb_mult_display_ctrl;

  localparam int SETTLE  = 2;
  localparam int BITS    = 4;
  localparam int MAXOFF  = 1;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, scroll_l = 1'b0, scroll_r = 1'b0;
  logic       mult_done = 1'b0, neg_a = 1'b0, neg_b = 1'b0;
  logic       mult_start, sr_load, sr_en, sr_dir, neg, busy, err;
  logic [1:0] offset;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: displayed offset, latched sign, and whether a result is on show.
  int m_off  = 0;
  bit m_neg  = 1'b0;
  bit m_show = 1'b0;

  always #5 clk = ~clk;

  mult_display_ctrl #(
    .SETTLE_CYC     (SETTLE),
    .BITS_PER_DIGIT (BITS),
    .MAX_OFFSET     (MAXOFF),
    .TIMEOUT_CYC    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .scroll_l   (scroll_l),
    .scroll_r   (scroll_r),
    .mult_done  (mult_done),
    .neg_a      (neg_a),
    .neg_b      (neg_b),
    .mult_start (mult_start),
    .sr_load    (sr_load),
    .sr_en      (sr_en),
    .sr_dir     (sr_dir),
    .offset     (offset),
    .neg        (neg),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mult_start"}, int'(mult_start), 0);
    check({tag, "_sr_load"},    int'(sr_load), 0);
    check({tag, "_sr_en"},      int'(sr_en), 0);
    check({tag, "_sr_dir"},     int'(sr_dir), 0);
    check({tag, "_offset"},     int'(offset), 0);
    check({tag, "_neg"},        int'(neg), 0);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_err"},        int'(err), 0);
  endtask

  // New product: start (optionally with scrolls), lat MULT cycles, then settle and load.
  task automatic do_start(input bit na, input bit nb, input int lat, input bit sl, input bit sr);
    int n;
    neg_a = na; neg_b = nb; start = 1'b1; scroll_l = sl; scroll_r = sr;
    tick;
    start = 1'b0; scroll_l = 1'b0; scroll_r = 1'b0;
    m_neg = na ^ nb; m_off = 0; m_show = 1'b0;
    check("mult_entered", int'(mult_start), 1);
    check("neg_latched", int'(neg), int'(m_neg));
    check("offset_cleared", int'(offset), 0);
    check("start_no_sr_en", int'(sr_en), 0);
    check("mult_busy", int'(busy), 1);
    for (int k = 1; k < lat; k++) begin
      tick;
      check("mult_hold", int'(mult_start), 1);
    end
    mult_done = 1'b1;
    tick;
    mult_done = 1'b0;
    check("settle_mult_off", int'(mult_start), 0);
    n = 1;
    while (sr_load !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check("load_latency", n, SETTLE + 1);
    check("load_no_sr_en", int'(sr_en), 0);
    tick;
    check("load_single", int'(sr_load), 0);
    check("show_not_busy", int'(busy), 0);
    check("show_offset", int'(offset), m_off);
    check("show_neg", int'(neg), int'(m_neg));
    m_show = 1'b1;
  endtask

  // Scroll request; optionally inject an opposite scroll / start during STEP.
  task automatic do_scroll(input bit l, input bit r, input bit interfere, input bit istart);
    int n;
    bit vl, vr;
    vl = m_show && l && !r && (m_off < MAXOFF);
    vr = m_show && r && !l && (m_off > 0);
    scroll_l = l; scroll_r = r;
    tick;
    scroll_l = 1'b0; scroll_r = 1'b0;
    if (vl || vr) begin
      n = 0;
      while (sr_en === 1'b1 && n < 20) begin
        check("step_dir", int'(sr_dir), vl ? 1 : 0);
        check("step_no_load", int'(sr_load), 0);
        if (n == 0 && interfere) begin
          scroll_l = vr; scroll_r = vl; start = istart;
        end else begin
          scroll_l = 1'b0; scroll_r = 1'b0; start = 1'b0;
        end
        tick;
        n++;
      end
      scroll_l = 1'b0; scroll_r = 1'b0; start = 1'b0;
      check("step_len", n, BITS);
      m_off += vl ? 1 : -1;
    end else begin
      n = 0;
      repeat (6) begin
        if (sr_en) n++;
        tick;
      end
      check("ignored_no_sr_en", n, 0);
    end
    check("offset", int'(offset), m_off);
    check("scroll_not_busy", int'(busy), 0);
    check("scroll_no_mult", int'(mult_start), 0);
  endtask

  initial begin
    int n;

    // Reset state, checked before any clock edge.
    #1;
    check_all_zero("reset");
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    check("idle_not_busy", int'(busy), 0);

    // Sign latch and load latency, mult_done 3 cycles after start.
    do_start(1'b1, 1'b0, 3, 1'b0, 1'b0);

    // Left to the limit, then a rejected extra left.
    do_scroll(1'b1, 1'b0, 1'b0, 1'b0);
    do_scroll(1'b1, 1'b0, 1'b0, 1'b0);

    // Both directions at once, then a right scroll with a dropped request mid-STEP.
    do_scroll(1'b1, 1'b1, 1'b0, 1'b0);
    do_scroll(1'b0, 1'b1, 1'b1, 1'b1);
    do_scroll(1'b0, 1'b1, 1'b0, 1'b0);

    // start and scroll_r together in SHOW at offset 1.
    do_scroll(1'b1, 1'b0, 1'b0, 1'b0);
    do_start(1'b0, 1'b1, 2, 1'b0, 1'b1);

    // Reset mid-STEP: sr_en must fall without a clock edge.
    scroll_l = 1'b1;
    tick;
    scroll_l = 1'b0;
    check("pre_reset_step", int'(sr_en), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick;
    rst_n = 1'b1;
    m_off = 0; m_neg = 1'b0; m_show = 1'b0;
    tick;
    check_all_zero("after_reset");
    do_scroll(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized mix of products and scrolls.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0 || !m_show)
        do_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_scroll(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MDC_WATCHDOG_EN
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      if (mult_start) n++;
      tick;
    end
    check("wd_mult_cycles", n, TIMEOUT);
    check("wd_err", int'(err), 1);
    check("wd_mult_off", int'(mult_start), 0);
    check("wd_busy", int'(busy), 1);
    tick;
    check("wd_err_sticky", int'(err), 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("wd_err_clear", int'(err), 0);
    check("wd_restart", int'(mult_start), 1);
    mult_done = 1'b1;
    tick;
    mult_done = 1'b0;
    repeat (SETTLE + 2) tick;
    check("wd_recovered", int'(busy), 0);
`else
    n = 0;
    check("err_tied_low", int'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
